// File: rtl/key_cmd_gen.sv
// Keyboard-to-game command generator: maps held HID keycodes to game commands
// with DAS/auto-repeat timing and a single-entry output buffer.
//
// state     | meaning
// ----------|----------------------------------------------------------
// ST_IDLE   | no mapped key held; nothing to repeat
// ST_DAS    | LEFT/RIGHT held, waiting out the delay before first repeat
// ST_REPEAT | LEFT/RIGHT or SOFT_DROP auto-repeating at its period
// ST_HOLD   | ROTATE/HARD_DROP held; already issued once, no repeat
module key_cmd_gen #(
  parameter int unsigned DAS_FRAMES  = 8,
  parameter int unsigned ARR_FRAMES  = 3,
  parameter int unsigned DROP_FRAMES = 2
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [2:0] cmd,
  output logic       cmd_drop
);

  typedef enum logic [1:0] {ST_IDLE, ST_DAS, ST_REPEAT, ST_HOLD} state_e;
  typedef enum logic [2:0] {
    CMD_NONE      = 3'd0,
    CMD_LEFT      = 3'd1,
    CMD_RIGHT     = 3'd2,
    CMD_SOFT_DROP = 3'd3,
    CMD_ROTATE    = 3'd4,
    CMD_HARD_DROP = 3'd5
  } cmd_e;

  // Terminal counts; parameters are expected in 1..255.
  localparam logic [7:0] DAS_LAST  = 8'(DAS_FRAMES - 1);
  localparam logic [7:0] ARR_LAST  = 8'(ARR_FRAMES - 1);
  localparam logic [7:0] DROP_LAST = 8'(DROP_FRAMES - 1);

  function automatic cmd_e key_to_cmd(input logic [7:0] k);
    case (k)
      8'h04:   return CMD_LEFT;
      8'h07:   return CMD_RIGHT;
      8'h16:   return CMD_SOFT_DROP;
      8'h1A:   return CMD_ROTATE;
      8'h2C:   return CMD_HARD_DROP;
      default: return CMD_NONE;
    endcase
  endfunction

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d, cnt_inc, rep_last;
  logic [7:0] prev_key;
  logic       cmd_valid_q, valid_d;
  cmd_e       cmd_q, cmd_d;
  logic       cmd_drop_q, drop_d;
  cmd_e       key_cmd;
  logic       gen;

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      prev_key    <= 8'h00;
      cmd_valid_q <= 1'b0;
      cmd_q       <= CMD_NONE;
      cmd_drop_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prev_key    <= keycode;
      cmd_valid_q <= valid_d;
      cmd_q       <= cmd_d;
      cmd_drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gen      = 1'b0;
    key_cmd  = key_to_cmd(keycode);
    cnt_inc  = (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;
    rep_last = (key_cmd == CMD_SOFT_DROP) ? DROP_LAST : ARR_LAST;

    if (key_cmd == CMD_NONE) begin
      state_d = ST_IDLE;
      cnt_d   = 8'd0;
    end else if (keycode != prev_key) begin
      // Any change to a mapped key restarts timing for the new key.
      gen   = 1'b1;
      cnt_d = 8'd0;
      case (key_cmd)
        CMD_LEFT, CMD_RIGHT: state_d = ST_DAS;
        CMD_SOFT_DROP:       state_d = ST_REPEAT;
        default:             state_d = ST_HOLD;
      endcase
    end else begin
      case (state_q)
        ST_DAS: begin
          if (cnt_q == DAS_LAST) begin
            gen     = 1'b1;
            state_d = ST_REPEAT;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_REPEAT: begin
          if (cnt_q == rep_last) begin
            gen   = 1'b1;
            cnt_d = 8'd0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: ;
      endcase
    end
  end

  // Single-entry buffer: a consume and a new load may happen on the same edge.
  always_comb begin
    valid_d = cmd_valid_q;
    cmd_d   = cmd_q;
    drop_d  = 1'b0;
    if (gen) begin
      if (!cmd_valid_q || cmd_ready) begin
        valid_d = 1'b1;
        cmd_d   = key_cmd;
      end else begin
        drop_d = 1'b1;
      end
    end else if (cmd_ready) begin
      valid_d = 1'b0;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd       = cmd_q;
  assign cmd_drop  = cmd_drop_q;

endmodule

// File: doc/key_cmd_gen.md
KEY_CMD_GEN -- requirements
Module: key_cmd_gen

Interface
REQ-001 Parameter DAS_FRAMES, default 8: frames from first press until first auto-repeat of LEFT/RIGHT.
REQ-002 Parameter ARR_FRAMES, default 3: frames between auto-repeats of LEFT/RIGHT after the DAS delay.
REQ-003 Parameter DROP_FRAMES, default 2: frames between repeats of SOFT_DROP.
REQ-004 frame_clk  in  1  frame-rate clock; all state SHALL update on its rising edge.
REQ-005 Reset  in  1  asynchronous, active-high reset.
REQ-006 keycode  in  8  USB HID keycode of the currently held key; 0x00 means no key.
REQ-007 cmd_ready  in  1  the game-logic stage accepts cmd this edge.
REQ-008 cmd_valid  out  1  cmd holds an unconsumed command.
REQ-009 cmd  out  3  0 NONE, 1 LEFT, 2 RIGHT, 3 SOFT_DROP, 4 ROTATE, 5 HARD_DROP.
REQ-010 cmd_drop  out  1  one-frame pulse: a generated command was discarded because the buffer was full.

Function
REQ-011 Key map SHALL be: 0x04 LEFT, 0x07 RIGHT, 0x16 SOFT_DROP, 0x1A ROTATE, 0x2C HARD_DROP; every other value, including 0x00, is unmapped.
REQ-012 keycode SHALL be registered each edge as prev_key; a "new press" is keycode != prev_key with keycode mapped.
REQ-013 FSM states SHALL be IDLE, DAS, REPEAT, HOLD, with an 8-bit frame counter cnt.
REQ-014 On a new press of LEFT/RIGHT: generate the command this edge, enter DAS, set cnt=0.
REQ-015 On a new press of SOFT_DROP: generate the command this edge, enter REPEAT, set cnt=0, use period DROP_FRAMES.
REQ-016 On a new press of ROTATE/HARD_DROP: generate the command exactly once and enter HOLD; no repeat while the key is held.
REQ-017 DAS: cnt increments each edge; when cnt==DAS_FRAMES-1, generate the command, enter REPEAT, and set cnt=0.
REQ-018 REPEAT: cnt increments; when cnt==period-1 (ARR_FRAMES for LEFT/RIGHT, DROP_FRAMES for SOFT_DROP), generate the command and set cnt=0.
REQ-019 If keycode becomes unmapped or 0x00 in any state, the FSM SHALL enter IDLE with cnt=0 and generate nothing.
REQ-020 A change directly from one mapped key to another mapped key SHALL be treated as a new press of the new key (REQ-014..016), cancelling the old repeat.
REQ-021 The output buffer SHALL hold one command; a generated command loads it when cmd_valid==0, or when cmd_valid==1 and cmd_ready==1 on the same edge (back-to-back, cmd_valid stays 1).
REQ-022 If cmd_valid==1 and cmd_ready==0 when a command is generated, that command SHALL be discarded, cmd_drop=1 for that frame, the buffered cmd SHALL be unchanged, and FSM/cnt SHALL advance normally.
REQ-023 If cmd_ready==1 and no command is generated, cmd_valid SHALL clear next edge; cmd_ready while cmd_valid==0 SHALL have no effect.
REQ-024 A buffered command SHALL remain valid after key release until it is consumed.
REQ-025 Latency: a new press at edge N SHALL give cmd_valid=1 after edge N when the buffer is free.
REQ-026 cnt SHALL saturate at 255 and never wrap; parameters SHALL be limited to 1..255.

Reset
REQ-027 While Reset is high: state=IDLE, cnt=0, prev_key=0x00, cmd_valid=0, cmd=0 (NONE), cmd_drop=0.
REQ-028 Reset asserted mid-DAS/REPEAT or with a pending cmd SHALL discard all pending state; after release, a key already held counts as a new press on the first edge.

Verification
REQ-029 Hold keycode=0x04 for 20 frames, cmd_ready=1 -> LEFT issued at frames 0, 8, 11, 14, 17 (defaults).
REQ-030 keycode=0x1A held for 10 frames, then 0x00, then 0x1A -> exactly two ROTATE commands, one per press.
REQ-031 keycode=0x16 held, cmd_ready=0 -> first SOFT_DROP latched; cmd_drop pulses at frames 2, 4, 6; cmd stays 3.
REQ-032 At frame 5 of a held 0x04, switch keycode to 0x07 -> RIGHT issued that edge; next RIGHT at +8 frames; no further LEFT.
REQ-033 A generated command with cmd_valid=1 and cmd_ready=1 on the same edge -> cmd_valid stays 1, cmd takes the new value, cmd_drop=0.
REQ-034 Assert Reset during REPEAT with cmd_valid=1 -> cmd_valid=0 immediately (asynchronous); held 0x07 after release -> RIGHT on the first edge.
